rev_serial_subtractor: RTL and testbench
========================================

REV_SERIAL_SUBTRACTOR -- requirements
Module: rev_serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 diff  output  WIDTH  difference a-b.
REQ-011 borrow_out  output  1  final borrow; 1 when a < b (unsigned).

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, when in_valid=1, the block SHALL capture a and b, clear the borrow register and bit counter, and go to SHIFT.
REQ-015 Each SHIFT cycle SHALL process exactly one bit, LSB first, through one reversible full-subtractor cell: d_i = a_i ^ b_i ^ br, br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 Result bits SHALL shift into a diff register from the MSB end, so diff is bit-aligned after WIDTH SHIFT cycles.
REQ-017 After the WIDTH-th SHIFT cycle the FSM SHALL enter DONE; latency from input acceptance to out_valid SHALL be exactly WIDTH+1 cycles.
REQ-018 diff SHALL equal (a - b) mod 2^WIDTH, and borrow_out SHALL equal the final borrow.
REQ-019 diff and borrow_out SHALL remain stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-020 In DONE with out_ready=1, the FSM SHALL return to IDLE on the next edge; a new operand pair SHALL be accepted no earlier than the following cycle (one transaction per WIDTH+2 cycles minimum).
REQ-021 in_valid SHALL be ignored in SHIFT and DONE; a and b changes there SHALL NOT affect the result in flight.
REQ-022 Operands a=b SHALL yield diff=0, borrow_out=0; a=0, b=2^WIDTH-1 SHALL yield diff=1, borrow_out=1.

Reset
REQ-023 With rst=1 at an edge, the state SHALL become IDLE, and diff, borrow_out, the borrow register and the counter SHALL clear to 0; in_ready=1 and out_valid=0 from the next cycle.
REQ-024 A reset asserted in SHIFT or DONE SHALL abort and discard the transaction in flight; no out_valid pulse SHALL follow.
REQ-025 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-026 Macro REV_SUB_SATURATE_EN: when defined, a final borrow of 1 SHALL force diff to 0 in DONE (borrow_out still 1); when undefined, diff SHALL be the modular result per REQ-018.

Structure
REQ-027 Shared package rev_pkg SHALL hold the FSM state enumeration typedef and the default WIDTH constant.
REQ-028 One sub-module, rev_full_subtractor (a, b, borrow_in -> diff, borrow_out plus garbage outputs, purely combinational), SHALL be instantiated once and reused each SHIFT cycle.

Verification
REQ-029 a=9, b=3, WIDTH=4 -> out_valid 5 cycles after acceptance, diff=6, borrow_out=0.
REQ-030 a=3, b=9 -> diff=10, borrow_out=1; with REV_SUB_SATURATE_EN defined, diff=0, borrow_out=1.
REQ-031 a=15, b=15, then a=0, b=15 -> diff=0/borrow 0, then diff=1/borrow 1.
REQ-032 out_ready held 0 for 10 cycles in DONE, with in_valid=1 and changing a/b -> diff stable, in_ready=0; result retired on out_ready=1, new pair accepted the cycle after IDLE is re-entered.
REQ-033 rst pulsed on the 2nd SHIFT cycle -> IDLE next cycle, outputs 0, no out_valid; a following a=7, b=2 transaction -> diff=5.
REQ-034 Randomized back-to-back transactions, random out_ready -> every result matches (a-b) mod 16 and borrow a<b; no transaction lost or duplicated.

Source files
------------

// File: rtl/rev_pkg.sv
// Shared definitions for the reversible serial subtractor.
// Holds the controller state enumeration and the default operand width.
package rev_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rev_full_subtractor.sv
// Reversible full-subtractor cell, purely combinational.
// Built from a CNOT (p = a ^ b) followed by a second CNOT for the difference
// and a Toffoli-style borrow term. The garbage outputs {a, a^b} are what the
// reversible gate network carries alongside the useful results, so the
// inputs stay recoverable from the outputs.
// Ports:
//   a, b        operand bits
//   borrow_in   incoming borrow
//   diff        a ^ b ^ borrow_in
//   borrow_out  (~a & b) | (~(a ^ b) & borrow_in)
//   garbage     {a, a ^ b}
module rev_full_subtractor (
    input  logic       a,
    input  logic       b,
    input  logic       borrow_in,
    output logic       diff,
    output logic       borrow_out,
    output logic [1:0] garbage
);

    logic p;

    assign p          = a ^ b;
    assign diff       = p ^ borrow_in;
    assign borrow_out = (~a & b) | (~p & borrow_in);
    assign garbage    = {a, p};

endmodule

// File: rtl/rev_serial_subtractor.sv
// Bit-serial unsigned subtractor using one reversible full-subtractor cell.
// Accepts an operand pair in IDLE, processes one bit per SHIFT cycle LSB
// first, then presents diff/borrow_out in DONE until the consumer accepts.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   in_valid      operand pair offered        in_ready   high only in IDLE
//   a, b          minuend / subtrahend
//   out_valid     high only in DONE           out_ready  consumer accepts
//   diff          (a - b) mod 2^WIDTH         borrow_out 1 when a < b
// Parameter WIDTH: 2..16.
// Build option REV_SUB_SATURATE_EN: when defined, a final borrow forces diff
// to 0 in DONE (borrow_out still 1).
module rev_serial_subtractor
    import rev_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef REV_SUB_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [CNT_W-1:0]  cnt;
    logic              br;
    logic              load;
    logic              shift_en;
    logic              last;
    logic              cell_d;
    logic              cell_br;
    logic [1:0]        unused_garbage;

    // Single cell reused every SHIFT cycle on the current LSBs.
    rev_full_subtractor u_cell (
        .a          (a_sr[0]),
        .b          (b_sr[0]),
        .borrow_in  (br),
        .diff       (cell_d),
        .borrow_out (cell_br),
        .garbage    (unused_garbage)
    );

    assign borrow_out = br;

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        last      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, registered handshakes and serial datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            diff      <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == ST_IDLE);
            out_valid <= (state_nxt == ST_DONE);
            if (load) begin
                a_sr <= a;
                b_sr <= b;
                cnt  <= '0;
                br   <= 1'b0;
            end else if (shift_en) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                cnt  <= cnt + CNT_W'(1);
                br   <= cell_br;
                // Result bits enter at the MSB so diff is aligned after WIDTH shifts.
                if (SATURATE && last && cell_br) begin
                    diff <= '0;
                end else begin
                    diff <= {cell_d, diff[WIDTH-1:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_rev_serial_subtractor.sv
// Self-checking bench for rev_serial_subtractor (WIDTH = 4).
module tb_rev_serial_subtractor;

    localparam int unsigned WIDTH = 4;
    localparam int          LAT   = WIDTH + 1;

`ifdef REV_SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rev_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    // Reference: plain unsigned arithmetic.
    function automatic logic [WIDTH-1:0] model_diff(input logic [WIDTH-1:0] av,
                                                   input logic [WIDTH-1:0] bv);
        logic [WIDTH-1:0] d;
        d = WIDTH'(int'(av) - int'(bv));
        if (SAT && (av < bv)) d = '0;
        return d;
    endfunction

    function automatic logic model_borrow(input logic [WIDTH-1:0] av,
                                          input logic [WIDTH-1:0] bv);
        return av < bv;
    endfunction

    // Offer one pair when ready; called and returns at a negedge.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) return;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ok = 1'b1;
    endtask

    // Cycles from acceptance to out_valid (first call is one cycle after acceptance).
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (diff !== '0) begin failures++; $display("FAIL reset_diff got=%0d exp=0", diff); end
        checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b exp=0", borrow_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        send(4'd9, 4'd3, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b exp=1", ok); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_busy_in_ready got=%b exp=0", in_ready); end
        wait_out(lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (diff !== 4'd6) begin failures++; $display("FAIL basic_diff got=%0d exp=6", diff); end
        checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL basic_borrow got=%b exp=0", borrow_out); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_done_in_ready got=%b exp=0", in_ready); end
        retire();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b%b exp=10", in_ready, out_valid); end
    endtask

    // Pairs with expected values taken from the reference model.
    task automatic test_pairs();
        logic [WIDTH-1:0] av [4];
        logic [WIDTH-1:0] bv [4];
        bit ok;
        int lat;
        av = '{4'd3, 4'd15, 4'd0, 4'd8};
        bv = '{4'd9, 4'd15, 4'd15, 4'd0};
        for (int i = 0; i < 4; i++) begin
            send(av[i], bv[i], ok);
            wait_out(lat);
            checks++; if (lat !== LAT) begin failures++; $display("FAIL pair%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            checks++; if (diff !== model_diff(av[i], bv[i])) begin failures++; $display("FAIL pair%0d_diff got=%0d exp=%0d", i, diff, model_diff(av[i], bv[i])); end
            checks++; if (borrow_out !== model_borrow(av[i], bv[i])) begin failures++; $display("FAIL pair%0d_borrow got=%b exp=%b", i, borrow_out, model_borrow(av[i], bv[i])); end
            retire();
        end
        // Spot values independent of the model function.
        send(4'd3, 4'd9, ok);
        wait_out(lat);
        checks++; if (diff !== (SAT ? 4'd0 : 4'd10)) begin failures++; $display("FAIL borrow_case_diff got=%0d exp=%0d", diff, SAT ? 0 : 10); end
        checks++; if (borrow_out !== 1'b1) begin failures++; $display("FAIL borrow_case_borrow got=%b exp=1", borrow_out); end
        retire();
        send(4'd0, 4'd15, ok);
        wait_out(lat);
        checks++; if (diff !== (SAT ? 4'd0 : 4'd1)) begin failures++; $display("FAIL zero_minus_max_diff got=%0d exp=%0d", diff, SAT ? 0 : 1); end
        retire();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [WIDTH-1:0] exp_d;
        send(4'd5, 4'd12, ok);
        // Operand changes and in_valid during SHIFT must not disturb the result.
        in_valid = 1'b1;
        a = 4'd1;
        b = 4'd1;
        wait_out(lat);
        exp_d = model_diff(4'd5, 4'd12);
        for (int i = 0; i < 10; i++) begin
            a = WIDTH'($urandom_range(0, 15));
            b = WIDTH'($urandom_range(0, 15));
            @(negedge clk);
            checks++; if (diff !== exp_d || borrow_out !== 1'b1) begin failures++; $display("FAIL hold%0d got=%0d/%b exp=%0d/1", i, diff, borrow_out, exp_d); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL hold%0d_hs got=%b%b exp=01", i, in_ready, out_valid); end
        end
        in_valid = 1'b0;
        retire();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b%b exp=10", in_ready, out_valid); end
        // Accepted in the first IDLE cycle.
        send(4'd11, 4'd4, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_next_accept got=%b exp=1", ok); end
        wait_out(lat);
        checks++; if (lat !== LAT || diff !== 4'd7) begin failures++; $display("FAIL bp_next got=lat%0d/%0d exp=lat%0d/7", lat, diff, LAT); end
        retire();
    endtask

    task automatic test_reset_abort();
        bit ok;
        int seen = 0;
        int lat;
        send(4'd6, 4'd1, ok);
        rst = 1'b1;            // second SHIFT cycle
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL abort_hs got=%b%b exp=10", in_ready, out_valid); end
        checks++; if (diff !== '0 || borrow_out !== 1'b0) begin failures++; $display("FAIL abort_outputs got=%0d/%b exp=0/0", diff, borrow_out); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_out got=%0d exp=0", seen); end
        // Reset wins over in_valid.
        rst = 1'b1;
        in_valid = 1'b1;
        a = 4'd9;
        b = 4'd9;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_priority got=%b exp=1", in_ready); end
        send(4'd7, 4'd2, ok);
        wait_out(lat);
        checks++; if (diff !== 4'd5 || borrow_out !== 1'b0) begin failures++; $display("FAIL post_abort got=%0d/%b exp=5/0", diff, borrow_out); end
        retire();
    endtask

    // Free-running random traffic against a queue of accepted pairs.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] qd[$];
        logic             qb[$];
        int done_cnt = 0;
        int sent_cnt = 0;
        int n = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = WIDTH'($urandom_range(0, 15));
            b         = WIDTH'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (in_valid && in_ready) begin
                qd.push_back(model_diff(a, b));
                qb.push_back(model_borrow(a, b));
                sent_cnt++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (qd.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra got=%0d/%b exp=none", diff, borrow_out);
                end else if (diff !== qd[0] || borrow_out !== qb[0]) begin
                    failures++;
                    $display("FAIL rand%0d got=%0d/%b exp=%0d/%b", done_cnt, diff, borrow_out, qd[0], qb[0]);
                end
                if (qd.size() != 0) begin
                    void'(qd.pop_front());
                    void'(qb.pop_front());
                end
                done_cnt++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        while (qd.size() != 0 && n < 50) begin
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                checks++;
                if (diff !== qd[0] || borrow_out !== qb[0]) begin
                    failures++;
                    $display("FAIL rand_drain got=%0d/%b exp=%0d/%b", diff, borrow_out, qd[0], qb[0]);
                end
                void'(qd.pop_front());
                void'(qb.pop_front());
                done_cnt++;
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        checks++; if (done_cnt !== sent_cnt || sent_cnt < 20) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", done_cnt, sent_cnt); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_pairs();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
